tie_fanout_checker: RTL and testbench
=====================================

# tie_fanout_checker

Synchronous checker that reads back the value seen at every sink of a tie-cell net (e.g. one LOGIC1_X1 driving 91 buffer inputs and 11 pad inputs) and reports whether all sinks carry the expected constant. It is the receiving end of the tie-fanout net, and the design uses it to confirm that tie-fanout repair did not break connectivity. It snapshots all sink values on `start`, scans them one per cycle, counts mismatches, records the first failing index, and signals completion with a one-cycle pulse.

## Interface
- `NUM_SINKS`, 102: number of sink lines checked (bits 0..90 are buffer inputs, 91..101 are pad inputs); legal range 1..1024.
- `EXPECT`, 1'b1: expected tie value (1 for LOGIC1, 0 for LOGIC0).
- `IDX_W`, derived localparam: `$clog2(NUM_SINKS)`, minimum 1.
- `CNT_W`, derived localparam: `$clog2(NUM_SINKS+1)`.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a check; accepted only in IDLE.
- `sink_vals`  in  NUM_SINKS  value observed at each sink.
- `busy`  out  1  high in SNAP, SCAN and REPORT.
- `done`  out  1  one-cycle pulse when results are valid.
- `pass`  out  1  high when the last check found 0 mismatches.
- `fail_count`  out  CNT_W  mismatch count from the last check.
- `first_fail_idx`  out  IDX_W  lowest mismatching index from the last check.
- `fail_valid`  out  1  `first_fail_idx` is meaningful (fail_count != 0).

## Operation
- FSM states: IDLE, SNAP, SCAN, REPORT.
- IDLE: if `start` is high, go to SNAP. Otherwise hold state and hold the last results.
- SNAP: register `sink_vals` into `snap`. Clear the working counter, first-fail register and found flag. Set `idx` = 0. Go to SCAN.
- SCAN: compare `snap[idx]` with `EXPECT`.
  - On mismatch: increment the working count (it cannot overflow, because CNT_W covers NUM_SINKS).
  - On the first mismatch only: latch `idx` into first-fail and set found.
  - If `idx == NUM_SINKS-1`, go to REPORT. Otherwise `idx++`. `idx` never wraps.
- REPORT: copy the working results to `fail_count`, `first_fail_idx` and `fail_valid`. Set `pass = (count == 0)` and pulse `done`. Return to IDLE.
- `start` is ignored outside IDLE; it is neither queued nor an error.
- `start` held high continuously produces back-to-back checks, with one IDLE cycle between REPORT and the next SNAP.
- `sink_vals` changes after SNAP do not affect the current check.
- Output registers are updated only in REPORT, so they are stable during a scan.

## Timing
- Reset value of every output is 0: `busy`, `done`, `pass`, `fail_count`, `first_fail_idx`, `fail_valid`. The state resets to IDLE.
- Reset asserted mid-operation aborts the check on the next edge. No `done` is produced and all outputs return to their reset values.
- For `start` sampled high in IDLE at edge 0:
  - SNAP at edge 1.
  - SCAN covers edges 2..NUM_SINKS+1.
  - REPORT at edge NUM_SINKS+2.
  - `done` and results are visible after edge NUM_SINKS+2.
  - Total latency is NUM_SINKS+2 cycles (104 for the default).
- `busy` rises after edge 1 and falls after edge NUM_SINKS+3, when the FSM is back in IDLE. `busy` is low while `done` is high... no: `busy` is still high during the REPORT cycle in which `done` pulses.
- NUM_SINKS == 1: SCAN lasts exactly one cycle and `IDX_W` = 1.

## Structure
- Shared include `tie_check_defs.vh` holds:
  - the state encodings (2-bit localparams `ST_IDLE`=0, `ST_SNAP`=1, `ST_SCAN`=2, `ST_REPORT`=3);
  - the default `NUM_SINKS`.
- Single module, no sub-modules. The index counter and mismatch counter are inline.
- Target 150–250 lines of RTL.

## Test plan
- All 102 sinks = 1, pulse `start` → `done` after 104 cycles; `pass`=1, `fail_count`=0, `fail_valid`=0.
- Sinks 7, 91 and 101 = 0 (others 1) → `fail_count`=3, `first_fail_idx`=7, `fail_valid`=1, `pass`=0.
- All sinks = 0 → `fail_count`=102, `first_fail_idx`=0.
- Flip sink 50 to 0 two cycles after `start`, then pulse `start` again mid-scan → result `pass`=1, and exactly one `done` is produced.
- Assert `rst` at cycle 40 of a scan → no `done`, all outputs 0 the next cycle, and a fresh `start` completes normally.
- `start` held high with sink 0 = 0 → consecutive `done` pulses 105 cycles apart, each reporting `fail_count`=1 and `first_fail_idx`=0.

Source files
------------

// File: rtl/tie_fanout_checker_pkg.sv
// -----------------------------------------------------------------------------
// tie_fanout_checker_pkg
// Shared definitions for the tie-fanout checker: FSM state encoding and the
// default sink count of the reference tie net (91 buffer inputs + 11 pads).
// -----------------------------------------------------------------------------
package tie_fanout_checker_pkg;

   localparam int unsigned DefaultNumSinks = 102;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSnap   = 2'd1,
      StScan   = 2'd2,
      StReport = 2'd3
   } state_e;

endpackage

// File: rtl/tie_fanout_checker.sv
// -----------------------------------------------------------------------------
// tie_fanout_checker
// Receiving end of a tie-cell fanout net. On start, all sink values are
// snapshotted, then scanned one per cycle against the expected tie constant.
// Mismatches are counted, and the lowest failing index is recorded. The
// results are published together with a one-cycle done pulse.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   request a check (accepted only when idle)
//   sink_vals      in   value observed at each sink
//   busy           out  check in progress (snap, scan, report)
//   done           out  one-cycle pulse, results valid
//   pass           out  last check found no mismatches
//   fail_count     out  mismatch count of the last check
//   first_fail_idx out  lowest mismatching index of the last check
//   fail_valid     out  first_fail_idx is meaningful
// -----------------------------------------------------------------------------
module tie_fanout_checker
   import tie_fanout_checker_pkg::*;
#(
   parameter int unsigned NUM_SINKS = DefaultNumSinks,
   parameter logic        EXPECT    = 1'b1,
   localparam int unsigned IDX_W    = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1,
   localparam int unsigned CNT_W    = $clog2(NUM_SINKS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_SINKS-1:0] sink_vals,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     fail_count,
   output logic [IDX_W-1:0]     first_fail_idx,
   output logic                 fail_valid
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SINKS - 1);

   state_e state_q, state_d;

   // Working state of the current check
   logic [NUM_SINKS-1:0] snap_q, snap_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     ff_q, ff_d;
   logic                 found_q, found_d;

   // Published results, only written in StReport
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [CNT_W-1:0]     fail_count_q, fail_count_d;
   logic [IDX_W-1:0]     first_fail_idx_q, first_fail_idx_d;
   logic                 fail_valid_q, fail_valid_d;

   always_comb begin
      state_d          = state_q;
      snap_d           = snap_q;
      idx_d            = idx_q;
      cnt_d            = cnt_q;
      ff_d             = ff_q;
      found_d          = found_q;
      pass_d           = pass_q;
      fail_count_d     = fail_count_q;
      first_fail_idx_d = first_fail_idx_q;
      fail_valid_d     = fail_valid_q;
      done_d           = 1'b0;
      // Registered view of the state: rises one cycle after leaving idle and
      // stays high through the cycle in which done pulses.
      busy_d           = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSnap;
            end
         end

         StSnap: begin
            snap_d  = sink_vals;
            idx_d   = '0;
            cnt_d   = '0;
            ff_d    = '0;
            found_d = 1'b0;
            state_d = StScan;
         end

         StScan: begin
            if (snap_q[idx_q] != EXPECT) begin
               // Cannot overflow: CNT_W holds NUM_SINKS
               cnt_d = cnt_q + CNT_W'(1);
               if (!found_q) begin
                  ff_d    = idx_q;
                  found_d = 1'b1;
               end
            end
            if (idx_q == LastIdx) begin
               state_d = StReport;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         StReport: begin
            fail_count_d     = cnt_q;
            first_fail_idx_d = ff_q;
            fail_valid_d     = found_q;
            pass_d           = (cnt_q == '0);
            done_d           = 1'b1;
            state_d          = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         snap_q           <= '0;
         idx_q            <= '0;
         cnt_q            <= '0;
         ff_q             <= '0;
         found_q          <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         fail_count_q     <= '0;
         first_fail_idx_q <= '0;
         fail_valid_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         snap_q           <= snap_d;
         idx_q            <= idx_d;
         cnt_q            <= cnt_d;
         ff_q             <= ff_d;
         found_q          <= found_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         fail_count_q     <= fail_count_d;
         first_fail_idx_q <= first_fail_idx_d;
         fail_valid_q     <= fail_valid_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign fail_count     = fail_count_q;
   assign first_fail_idx = first_fail_idx_q;
   assign fail_valid     = fail_valid_q;

endmodule

// File: tb/tb_tie_fanout_checker.sv
// -----------------------------------------------------------------------------
// tb_tie_fanout_checker
// Directed and randomized checks of tie_fanout_checker against a reference
// model that simply counts sinks differing from the tie value.
// -----------------------------------------------------------------------------
module tb_tie_fanout_checker;

   localparam int N      = 102;
   localparam int CNT_W  = $clog2(N + 1);
   localparam int IDX_W  = $clog2(N);
   localparam logic EXP  = 1'b1;
   localparam int LAT    = N + 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [N-1:0]     sink_vals;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] fail_count;
   logic [IDX_W-1:0] first_fail_idx;
   logic             fail_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   tie_fanout_checker #(
      .NUM_SINKS (N),
      .EXPECT    (EXP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .sink_vals      (sink_vals),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_count     (fail_count),
      .first_fail_idx (first_fail_idx),
      .fail_valid     (fail_valid)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: count sinks not at the tie value, lowest such index
   function automatic void model(input logic [N-1:0] v, output int cnt, output int first);
      cnt   = 0;
      first = -1;
      for (int i = 0; i < N; i++) begin
         if (v[i] !== EXP) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
   endfunction

   task automatic chk_results(input string tag, input logic [N-1:0] v);
      int cnt, first;
      model(v, cnt, first);
      chk({tag, ".pass"},       32'(pass),           32'(cnt == 0));
      chk({tag, ".fail_count"}, 32'(fail_count),     32'(cnt));
      chk({tag, ".fail_valid"}, 32'(fail_valid),     32'(cnt != 0));
      chk({tag, ".first_idx"},  32'(first_fail_idx), (cnt == 0) ? 32'd0 : 32'(first));
   endtask

   // Pulse start with vector v, wait for done, check latency and results
   task automatic run_check(input string tag, input logic [N-1:0] v);
      int k;
      bit got;
      sink_vals = v;
      start     = 1'b1;
      step();                         // edge 0
      start = 1'b0;
      chk({tag, ".busy_e0"}, 32'(busy), 32'd0);
      got = 1'b0;
      k   = 0;
      while (!got && k < LAT + 20) begin
         step();
         k++;
         if (k == 1) chk({tag, ".busy_e1"}, 32'(busy), 32'd1);
         if (done) got = 1'b1;
      end
      chk({tag, ".latency"}, 32'(got ? k : -1), 32'(LAT));
      chk({tag, ".busy_done"}, 32'(busy), 32'd1);
      chk_results(tag, v);
      step();
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
      chk_results({tag, ".hold"}, v);
   endtask

   function automatic logic [N-1:0] rand_vec(input int zero_pct);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(99) < zero_pct) ? 1'b0 : 1'b1;
      return v;
   endfunction

   initial begin
      logic [N-1:0] v;
      int dones;
      int t[$];

      rst       = 1'b1;
      start     = 1'b0;
      sink_vals = '1;
      step();
      step();
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.pass", 32'(pass), 32'd0);
      chk("rst.fail_count", 32'(fail_count), 32'd0);
      chk("rst.first_idx", 32'(first_fail_idx), 32'd0);
      chk("rst.fail_valid", 32'(fail_valid), 32'd0);
      rst = 1'b0;
      step();

      // All sinks tied correctly
      run_check("all_ones", '1);

      // Sinks 7, 91, 101 broken
      v = '1;
      v[7] = 1'b0; v[91] = 1'b0; v[101] = 1'b0;
      run_check("three_bad", v);
      chk("three_bad.count3", 32'(fail_count), 32'd3);
      chk("three_bad.idx7", 32'(first_fail_idx), 32'd7);

      // Every sink wrong
      run_check("all_zero", '0);
      chk("all_zero.count", 32'(fail_count), 32'd102);

      // Last sink only (boundary index)
      v = '1;
      v[N-1] = 1'b0;
      run_check("last_only", v);

      // Randomized patterns of varying density
      for (int r = 0; r < 6; r++) begin
         run_check($sformatf("rand%0d", r), rand_vec((r == 0) ? 1 : r * 15));
      end

      // Input change after snapshot and a second start mid-scan are ignored
      sink_vals = '1;
      start     = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      v = '1;
      v[50] = 1'b0;
      sink_vals = v;
      repeat (10) step();
      start = 1'b1;
      step();
      start = 1'b0;
      dones = 0;
      for (int k = 0; k < 2 * LAT; k++) begin
         if (done) begin
            dones++;
            chk("late_change.pass", 32'(pass), 32'd1);
            chk("late_change.count", 32'(fail_count), 32'd0);
         end
         step();
      end
      chk("late_change.dones", 32'(dones), 32'd1);

      // Reset in the middle of a scan aborts the check
      v = '1;
      v[3] = 1'b0;
      sink_vals = v;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (40) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.pass", 32'(pass), 32'd0);
      chk("abort.fail_count", 32'(fail_count), 32'd0);
      chk("abort.first_idx", 32'(first_fail_idx), 32'd0);
      chk("abort.fail_valid", 32'(fail_valid), 32'd0);
      dones = 0;
      for (int k = 0; k < LAT + 10; k++) begin
         if (done) dones++;
         step();
      end
      chk("abort.no_done", 32'(dones), 32'd0);
      run_check("after_abort", rand_vec(10));

      // Held start: back-to-back checks one idle cycle apart
      v = '1;
      v[0] = 1'b0;
      sink_vals = v;
      start = 1'b1;
      for (int k = 0; k < 3 * LAT && t.size() < 2; k++) begin
         step();
         if (done) begin
            t.push_back(cyc);
            chk("held.count", 32'(fail_count), 32'd1);
            chk("held.idx", 32'(first_fail_idx), 32'd0);
            chk("held.valid", 32'(fail_valid), 32'd1);
         end
      end
      start = 1'b0;
      chk("held.num_dones", 32'(t.size()), 32'd2);
      if (t.size() == 2) chk("held.spacing", 32'(t[1] - t[0]), 32'(LAT + 1));
      repeat (LAT + 5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
